// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-master memory arbiter: FSM state encodings
// and the default bus widths used by mem_arbiter.
// Configuration macro: MEM_ARB_RR_EN (see rr_arbiter2 / mem_arbiter).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,   // waiting for a request, arbitrates
      ACCESS = 2'd1,   // RAM address/data presented, write strobe if write
      RESP   = 2'd2    // ack pulse to the owner, read data returned
   } arb_state_t;

endpackage : mem_arb_pkg

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester grant logic (purely combinational).
//   i_req[1:0]  : request vector, bit n = master n
//   i_pointer   : round-robin pointer, master favoured on contention
//   o_grant[1:0]: one-hot grant, all-zero when nothing is requested
// Configuration macro: MEM_ARB_RR_EN
//   defined   -> round-robin, contention grants the pointed master
//   undefined -> fixed priority, master 0 always wins; i_pointer is ignored
// -----------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_pointer,
   output logic [1:0] o_grant
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      o_grant = 2'b00;
      if (i_req == 2'b11) begin
         o_grant = i_pointer ? 2'b10 : 2'b01;
      end else begin
         // at most one requester: it simply wins
         o_grant = i_req;
      end
   end
`else
   // The pointer has no meaning under fixed priority.
   logic w_unused_pointer;
   assign w_unused_pointer = i_pointer;

   always_comb begin
      o_grant = 2'b00;
      if (i_req[0]) begin
         o_grant = 2'b01;
      end else if (i_req[1]) begin
         o_grant = 2'b10;
      end
   end
`endif

endmodule : rr_arbiter2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous RAM between a CPU memory stage (m0) and a secondary
// master such as a loader/DMA (m1). Each access takes IDLE -> ACCESS -> RESP:
// req-high to ack is 2 cycles, one access every 3 cycles.
//
// Ports
//   clk, rst                 : clock (rising edge), async active-low reset
//   mN_req/mN_we             : request and write flag of master N
//   mN_addr/mN_wdata         : address and store data of master N
//   mN_ack                   : one-cycle completion pulse (RESP state)
//   mN_rdata                 : load data, held between reads
//   ram_address/ram_data_in  : registered RAM address and write data
//   ram_write_enable         : registered write strobe, high in ACCESS only
//   ram_data_out             : RAM read data, valid one cycle after address
//   busy/owner               : access in progress / master being served
//
// Configuration macro: MEM_ARB_RR_EN (round-robin instead of fixed priority
// with m0 winning; only the round-robin build has a pointer register).
//
// Addresses pass through unmodified; peripheral decode happens downstream.
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,

   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_write_enable,
   input  logic [DATA_W-1:0] ram_data_out,

   output logic              busy,
   output logic              owner
);

   arb_state_t        r_state;
   arb_state_t        w_next_state;

   logic              r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_ram_address;
   logic [DATA_W-1:0] r_ram_data_in;
   logic              r_ram_we;
   logic [DATA_W-1:0] r_m0_rdata;
   logic [DATA_W-1:0] r_m1_rdata;

   logic [1:0]        w_req;
   logic [1:0]        w_grant;
   logic              w_pointer;
   logic              w_win;          // winning master index

   logic              w_m0_ack;
   logic              w_m1_ack;
   logic              w_busy;
   logic [DATA_W-1:0] w_m0_rdata;
   logic [DATA_W-1:0] w_m1_rdata;

   assign w_req = {m1_req, m0_req};
   assign w_win = w_grant[1];

`ifdef MEM_ARB_RR_EN
   logic r_rr_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr <= 1'b0;
      end else if (r_state == IDLE && w_grant != 2'b00) begin
         // point at the master that was not just served
         r_rr_ptr <= w_grant[0];
      end
   end

   assign w_pointer = r_rr_ptr;
`else
   assign w_pointer = 1'b0;
`endif

   rr_arbiter2 u_rr_arbiter2 (
      .i_req     (w_req),
      .i_pointer (w_pointer),
      .o_grant   (w_grant)
   );

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_owner       <= 1'b0;
         r_we          <= 1'b0;
         r_ram_address <= '0;
         r_ram_data_in <= '0;
         r_ram_we      <= 1'b0;
         r_m0_rdata    <= '0;
         r_m1_rdata    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (w_grant != 2'b00) begin
                  r_owner       <= w_win;
                  r_we          <= w_win ? m1_we    : m0_we;
                  r_ram_address <= w_win ? m1_addr  : m0_addr;
                  r_ram_data_in <= w_win ? m1_wdata : m0_wdata;
                  r_ram_we      <= w_win ? m1_we    : m0_we;
               end
            end
            ACCESS: begin
               // write strobe covers the ACCESS cycle only
               r_ram_we <= 1'b0;
            end
            RESP: begin
               if (!r_we) begin
                  if (r_owner) begin
                     r_m1_rdata <= ram_data_out;
                  end else begin
                     r_m0_rdata <= ram_data_out;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_m0_ack     = 1'b0;
      w_m1_ack     = 1'b0;
      w_busy       = 1'b0;
      w_m0_rdata   = r_m0_rdata;
      w_m1_rdata   = r_m1_rdata;
      case (r_state)
         IDLE: begin
            if (w_req != 2'b00) begin
               w_next_state = ACCESS;
            end
         end
         ACCESS: begin
            w_busy       = 1'b1;
            w_next_state = RESP;
         end
         RESP: begin
            w_busy       = 1'b1;
            w_next_state = IDLE;
            // RAM data only becomes valid in RESP, so it is forwarded to the
            // owner alongside the ack and registered at the end of RESP to
            // hold it between reads.
            if (r_owner) begin
               w_m1_ack = 1'b1;
               if (!r_we) begin
                  w_m1_rdata = ram_data_out;
               end
            end else begin
               w_m0_ack = 1'b1;
               if (!r_we) begin
                  w_m0_rdata = ram_data_out;
               end
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign m0_ack           = w_m0_ack;
   assign m1_ack           = w_m1_ack;
   assign m0_rdata         = w_m0_rdata;
   assign m1_rdata         = w_m1_rdata;
   assign busy             = w_busy;
   assign owner            = r_owner;
   assign ram_address      = r_ram_address;
   assign ram_data_in      = r_ram_data_in;
   assign ram_write_enable = r_ram_we;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small synchronous RAM model.
// Build with or without MEM_ARB_RR_EN; contention expectations follow it.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_ack, m1_ack;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in;
   logic          ram_write_enable;
   logic [DW-1:0] ram_data_out;
   logic          busy, owner;

   int checks = 0;
   int errors = 0;

   // RAM model: synchronous read, data one cycle after address; bench load port
   logic [DW-1:0] mem [0:255];
   logic          ld_en = 1'b0;
   logic [7:0]    ld_addr = '0;
   logic [DW-1:0] ld_data = '0;

   int we_cycles = 0;
   int m0_acks   = 0;
   int m1_acks   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (ram_write_enable) mem[ram_address[7:0]] <= ram_data_in;
      ram_data_out <= mem[ram_address[7:0]];
      if (ram_write_enable) we_cycles <= we_cycles + 1;
      if (m0_ack) m0_acks <= m0_acks + 1;
      if (m1_ack) m1_acks <= m1_acks + 1;
   end

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk              (clk),
      .rst              (rst),
      .m0_req           (m0_req),
      .m0_we            (m0_we),
      .m0_addr          (m0_addr),
      .m0_wdata         (m0_wdata),
      .m0_ack           (m0_ack),
      .m0_rdata         (m0_rdata),
      .m1_req           (m1_req),
      .m1_we            (m1_we),
      .m1_addr          (m1_addr),
      .m1_wdata         (m1_wdata),
      .m1_ack           (m1_ack),
      .m1_rdata         (m1_rdata),
      .ram_address      (ram_address),
      .ram_data_in      (ram_data_in),
      .ram_write_enable (ram_write_enable),
      .ram_data_out     (ram_data_out),
      .busy             (busy),
      .owner            (owner)
   );

   // Preload one RAM word through the model's load port; ends on a negedge.
   task automatic load_word(input logic [7:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Wait (bounded) for master m's ack; cycles counts negedges from the call.
   task automatic wait_ack(input int m, input int budget, output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cycles++;
         if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
      #12;
      checks++;
      if ({ram_write_enable, busy, owner, m0_ack, m1_ack} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {ram_write_enable, busy, owner, m0_ack, m1_ack});
      end
      checks++;
      if ({ram_address, ram_data_in} !== '0) begin
         errors++;
         $display("FAIL reset_ram_bus: got addr=%h din=%h expected 0", ram_address, ram_data_in);
      end
      checks++;
      if ({m0_rdata, m1_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_rdata: got %h/%h expected 0", m0_rdata, m1_rdata);
      end
      checks++;
      if (dut.r_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d expected %0d", dut.r_state, IDLE);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_read();
      int  cyc;
      bit  ok;
      int  we0;
      load_word(8'h10, 32'hDEADBEEF);
      we0 = we_cycles;
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      wait_ack(0, 8, cyc, ok);
      checks++;
      if (!ok || cyc != 2) begin
         errors++;
         $display("FAIL read_latency: got ok=%0d cycles=%0d expected ok=1 cycles=2", ok, cyc);
      end
      checks++;
      if (m0_rdata !== 32'hDEADBEEF || m1_ack !== 1'b0 || owner !== 1'b0) begin
         errors++;
         $display("FAIL read_data: got rdata=%h m1_ack=%b owner=%b expected DEADBEEF/0/0", m0_rdata, m1_ack, owner);
      end
      m0_req = 0;
      @(negedge clk);
      checks++;
      if (m0_ack !== 1'b0 || busy !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_hold: got ack=%b busy=%b rdata=%h expected 0/0/DEADBEEF", m0_ack, busy, m0_rdata);
      end
      checks++;
      if (we_cycles - we0 != 0) begin
         errors++;
         $display("FAIL read_no_we: got %0d write cycles expected 0", we_cycles - we0);
      end
   endtask

   task automatic test_write_then_read();
      int cyc;
      bit ok;
      int we0;
      we0 = we_cycles;
      m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h1234;
      wait_ack(1, 8, cyc, ok);
      checks++;
      if (!ok || cyc != 2 || owner !== 1'b1 || m1_rdata !== '0) begin
         errors++;
         $display("FAIL write_ack: got ok=%0d cycles=%0d owner=%b rdata=%h expected 1/2/1/0", ok, cyc, owner, m1_rdata);
      end
      m1_req = 0; m1_we = 0;
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 32'h20;
      wait_ack(0, 8, cyc, ok);
      checks++;
      if (!ok || m0_rdata !== 32'h1234) begin
         errors++;
         $display("FAIL write_readback: got ok=%0d rdata=%h expected 1/00001234", ok, m0_rdata);
      end
      m0_req = 0;
      @(negedge clk);
      checks++;
      if (we_cycles - we0 != 1 || m1_rdata !== '0) begin
         errors++;
         $display("FAIL write_we_count: got we=%0d m1_rdata=%h expected 1/0", we_cycles - we0, m1_rdata);
      end
   endtask

   task automatic test_contention();
      logic        exp_owner [6];
      logic [DW-1:0] exp_data;
      int          n;
      int          cyc;
      int          m1_start;
      int          exp_m1;
`ifdef MEM_ARB_RR_EN
      exp_owner = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_m1    = 3;
`else
      exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_m1    = 0;
`endif
      // fresh reset so the round-robin pointer starts at m0
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      load_word(8'h30, 32'hA0A0A0A0);
      load_word(8'h31, 32'hB1B1B1B1);
      m1_start = m1_acks;
      m0_req = 1; m0_we = 0; m0_addr = 32'h30;
      m1_req = 1; m1_we = 0; m1_addr = 32'h31;
      n   = 0;
      cyc = 0;
      for (int i = 0; i < 40 && n < 6; i++) begin
         @(negedge clk);
         cyc++;
         if (m0_ack || m1_ack) begin
            exp_data = exp_owner[n] ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
            checks++;
            if (owner !== exp_owner[n] || m0_ack !== ~exp_owner[n] || m1_ack !== exp_owner[n]) begin
               errors++;
               $display("FAIL contend_owner[%0d]: got owner=%b acks=%b%b expected owner=%b", n, owner, m1_ack, m0_ack, exp_owner[n]);
            end
            checks++;
            if ((exp_owner[n] ? m1_rdata : m0_rdata) !== exp_data) begin
               errors++;
               $display("FAIL contend_data[%0d]: got %h expected %h", n, exp_owner[n] ? m1_rdata : m0_rdata, exp_data);
            end
            n++;
         end
      end
      m0_req = 0; m1_req = 0;
      checks++;
      if (n != 6 || cyc != 17) begin
         errors++;
         $display("FAIL contend_rate: got %0d acks in %0d cycles expected 6 in 17", n, cyc);
      end
      @(negedge clk);
      checks++;
      if (m1_acks - m1_start != exp_m1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL contend_m1_total: got %0d busy=%b expected %0d busy=0", m1_acks - m1_start, busy, exp_m1);
      end
   endtask

   task automatic test_reset_mid_write();
      int a0;
      load_word(8'h40, 32'h0BAD0BAD);
      a0 = m0_acks;
      m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h55555555;
      @(negedge clk);
      checks++;
      if (ram_write_enable !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_access: got we=%b busy=%b expected 1/1", ram_write_enable, busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({ram_write_enable, busy, m0_ack, owner} !== 4'b0 || ram_address !== '0 || dut.r_state !== IDLE) begin
         errors++;
         $display("FAIL rst_abort: got we=%b busy=%b ack=%b owner=%b addr=%h state=%0d expected all 0",
                  ram_write_enable, busy, m0_ack, owner, ram_address, dut.r_state);
      end
      m0_req = 0; m0_we = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (m0_acks - a0 != 0 || mem[8'h40] !== 32'h0BAD0BAD || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_ack: got acks=%0d mem=%h busy=%b expected 0/0BAD0BAD/0", m0_acks - a0, mem[8'h40], busy);
      end
   endtask

   task automatic test_req_drop();
      int a0;
      a0 = m0_acks;
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || owner !== 1'b0) begin
         errors++;
         $display("FAIL drop_access: got busy=%b owner=%b expected 1/0", busy, owner);
      end
      m0_req = 0;
      m1_req = 1; m1_we = 0; m1_addr = 32'h31;
      @(negedge clk);
      checks++;
      if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL drop_ack: got m0_ack=%b m1_ack=%b rdata=%h expected 1/0/DEADBEEF", m0_ack, m1_ack, m0_rdata);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m0_ack !== 1'b0) begin
         errors++;
         $display("FAIL drop_idle: got busy=%b m0_ack=%b expected 0/0", busy, m0_ack);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || owner !== 1'b1) begin
         errors++;
         $display("FAIL drop_m1_grant: got busy=%b owner=%b expected 1/1", busy, owner);
      end
      @(negedge clk);
      checks++;
      if (m1_ack !== 1'b1 || m1_rdata !== 32'hB1B1B1B1 || m0_acks - a0 != 1) begin
         errors++;
         $display("FAIL drop_m1_done: got ack=%b rdata=%h m0_acks=%0d expected 1/B1B1B1B1/1", m1_ack, m1_rdata, m0_acks - a0);
      end
      m1_req = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_then_read();
      test_contention();
      test_reset_mid_write();
      test_req_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case anything above stalls.
   initial begin
      #50000;
      $display("FAIL timeout: got no completion expected finish before 50000");
      $fatal(1);
   end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the address bus.
REQ-002 SHALL have parameter DATA_W, default 32, width of the data bus.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports m0_req/m0_we, input, 1 each, CPU memory-stage request and write flag.
REQ-006 SHALL have ports m0_addr (ADDR_W) and m0_wdata (DATA_W), both inputs, CPU address and store data.
REQ-007 SHALL have ports m0_ack (output, 1) and m0_rdata (output, DATA_W), CPU completion pulse and load data.
REQ-008 SHALL have ports m1_req, m1_we, m1_addr, m1_wdata, m1_ack and m1_rdata, identical to the m0_* ports, for the secondary master (loader/DMA).
REQ-009 SHALL have outputs ram_address (ADDR_W), ram_data_in (DATA_W) and ram_write_enable (1), all registered and driving the shared RAM.
REQ-010 SHALL have input ram_data_out, DATA_W, RAM read data, valid one cycle after the address.
REQ-011 SHALL have outputs busy (1) and owner (1), access in progress and the master being served.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-013 SHALL arbitrate in IDLE when any req is high, latch the winner's we/addr/wdata into the RAM output registers and go to ACCESS.
REQ-014 SHALL assert ram_write_enable in ACCESS only, for exactly one cycle, and only if the latched we=1.
REQ-015 SHALL go from ACCESS to RESP, pulse the owner's ack for one cycle, and capture ram_data_out into the owner's rdata on reads.
REQ-016 SHALL go from RESP to IDLE unconditionally, with latency req-high to ack of 2 cycles and throughput of 1 access per 3 cycles.
REQ-017 SHALL hold rdata between reads, leave it unchanged on writes, and never assert an ack to the non-owner.
REQ-018 SHALL, with both reqs high in IDLE, grant per REQ-026/REQ-027.
REQ-019 SHALL complete an access whose req drops after grant, including the ack pulse; the requester ignores it.
REQ-020 SHALL ignore req in ACCESS and RESP; masters hold req, we, addr and wdata stable until ack.
REQ-021 SHALL drive busy=1 in ACCESS/RESP, and owner = latched winner, held in IDLE.
REQ-022 SHALL pass addresses through unmodified, with peripheral decode (top 3 bits) done downstream.

Reset
REQ-023 SHALL, with rst low at any time including mid-access, immediately force state IDLE, ram_write_enable=0, acks=0, busy=0, owner=0, ram_address=0, ram_data_in=0, both rdata=0, rr pointer=0.
REQ-024 SHALL issue no ack for an access aborted by reset, and restart it only after re-arbitration.
REQ-025 SHALL allow the first arbitration on the first clk edge after rst rises.

Configuration
REQ-026 SHALL, with macro MEM_ARB_RR_EN defined, arbitrate round-robin: the pointer points at the master not served last, and contention grants the pointed master.
REQ-027 SHALL, without MEM_ARB_RR_EN, use fixed priority with m0 always winning contention and no pointer register.

Structure
REQ-028 SHALL place state encodings (IDLE/ACCESS/RESP) and default widths in shared package mem_arb_pkg.
REQ-029 SHALL use one sub-module, rr_arbiter2 (req[1:0], pointer -> grant one-hot), containing the MEM_ARB_RR_EN selection.

Verification
REQ-030 SHALL verify a single m0 read at addr 0x10 holding 0xDEADBEEF: m0_ack 2 cycles after req, m0_rdata=0xDEADBEEF, and ram_write_enable never high.
REQ-031 SHALL verify m1 write 0x1234 to 0x20 then m0 read of 0x20: exactly one write-enable cycle, and m0_rdata=0x1234.
REQ-032 SHALL verify both reqs held high for 6 accesses: with RR, owners alternate 0,1,0,1,0,1; without RR, all go to m0.
REQ-033 SHALL verify rst pulled low during ACCESS of a write: ram_write_enable drops the same cycle, no ack, and state IDLE.
REQ-034 SHALL verify m0 req dropped in ACCESS: m0_ack still pulses once, and m1 then granted next IDLE.
